not_a_dinosaur_runner: RTL and testbench

- Tiny-Tapeout-style endless-runner game core: a player that never moves sideways jumps over obstacles that scroll toward it along a 1-D lane.
- Top-level user block using the standard 8-in/8-out/8-bidir pin set; the player and game status go on uo_out and the score goes on uio_out.
- All game state advances on an internal game tick derived from clk.

---
 rtl/not_a_dinosaur_runner_pkg.sv | 32 +++
 rtl/not_a_dinosaur_lfsr8.sv | 31 +++
 rtl/not_a_dinosaur_runner.sv | 139 +++++++++++++
 tb/tb_not_a_dinosaur_runner.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/not_a_dinosaur_runner_pkg.sv
// Shared definitions for the endless-runner core: FSM states, jump profile,
// LFSR constants and pin bit positions.
package not_a_dinosaur_runner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  localparam logic [7:0] LFSR_SEED = 8'h01;
  // Right-shifting Galois form of x^8+x^6+x^5+x^4+1
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Height per jump counter value, entry for jcnt=0 in the low bits
  localparam logic [23:0] JUMP_TABLE = {3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0};

  localparam int UI_JUMP  = 0;
  localparam int UI_START = 1;
  localparam int UI_PAUSE = 2;

  localparam int UO_HEIGHT_LSB = 0;
  localparam int UO_OBST       = 4;
  localparam int UO_OVER       = 5;
  localparam int UO_RUN        = 6;
  localparam int UO_TICK       = 7;

  function automatic logic [2:0] jump_height(input logic [2:0] jcnt);
    return JUMP_TABLE[3*jcnt +: 3];
  endfunction

endpackage

// File: rtl/not_a_dinosaur_lfsr8.sv
// Free-running 8-bit Galois LFSR; advances every enabled clock, reseeded only by rst.
module not_a_dinosaur_lfsr8
  import not_a_dinosaur_runner_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 8'h00);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/not_a_dinosaur_runner.sv
// Endless-runner game core: prescaled game tick, scrolling obstacle lane,
// fixed-profile jump, saturating score and IDLE/RUN/OVER control.
module not_a_dinosaur_runner
  import not_a_dinosaur_runner_pkg::*;
#(
  parameter int TICK_DIV = 1024,
  parameter int LANE_LEN = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

  state_e                state_q, state_d;
  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [LANE_LEN-1:0]   lane_q, lane_d;
  logic [2:0]            jcnt_q, jcnt_d;
  logic [2:0]            height_q, height_d;
  logic [7:0]            score_q, score_d;
  logic                  tick_q, tick_d;

  logic [7:0]            lfsr;
  logic                  jump, start, pause;
  logic                  spawn, collide;
  logic [2:0]            jcnt_n, height_n;
  logic [LANE_LEN-1:0]   lane_n;
  logic                  unused_inputs;

  assign jump  = ui_in[UI_JUMP];
  assign start = ui_in[UI_START];
  assign pause = ui_in[UI_PAUSE];
  assign unused_inputs = ^{uio_in, ui_in[7:3]};

  not_a_dinosaur_lfsr8 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .en_i   (ena),
    .lfsr_o (lfsr)
  );

  // Candidate post-tick game values, all derived from pre-tick state
  always_comb begin
    jcnt_n = 3'd0;
    if (jcnt_q == 3'd0 && height_q == 3'd0 && jump) begin
      jcnt_n = 3'd1;
    end else if (jcnt_q != 3'd0) begin
      jcnt_n = jcnt_q + 3'd1;
    end
    height_n = jump_height(jcnt_n);
    spawn    = (lfsr[2:0] == 3'd0) && (lane_q[LANE_LEN-1 -: 3] == 3'b000);
    lane_n   = {spawn, lane_q[LANE_LEN-1:1]};
    collide  = lane_n[0] && (height_n == 3'd0);
  end

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    lane_d   = lane_q;
    jcnt_d   = jcnt_q;
    height_d = height_q;
    score_d  = score_q;
    tick_d   = 1'b0;
    if (!ena) begin
      tick_d = tick_q;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!pause) begin
            if (presc_q == PRESC_MAX) begin
              presc_d  = '0;
              tick_d   = 1'b1;
              jcnt_d   = jcnt_n;
              height_d = height_n;
              lane_d   = lane_n;
              if (collide) begin
                state_d = ST_OVER;
              end else if (score_q != 8'hFF) begin
                score_d = score_q + 8'd1;
              end
            end else begin
              presc_d = presc_q + PRESC_W'(1);
            end
          end
        end
        default: begin
          if (start) begin
            state_d  = ST_RUN;
            presc_d  = '0;
            lane_d   = '0;
            jcnt_d   = 3'd0;
            height_d = 3'd0;
            score_d  = 8'd0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      lane_q   <= '0;
      jcnt_q   <= 3'd0;
      height_q <= 3'd0;
      score_q  <= 8'd0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      lane_q   <= lane_d;
      jcnt_q   <= jcnt_d;
      height_q <= height_d;
      score_q  <= score_d;
      tick_q   <= tick_d;
    end
  end

  always_comb begin
    uo_out                          = 8'h00;
    uo_out[UO_HEIGHT_LSB +: 3]      = height_q;
    uo_out[UO_OBST]                 = lane_q[0];
    uo_out[UO_OVER]                 = (state_q == ST_OVER);
    uo_out[UO_RUN]                  = (state_q == ST_RUN);
    uo_out[UO_TICK]                 = tick_q;
  end

  assign uio_out = score_q;
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_not_a_dinosaur_runner.sv
// Randomised bench for the endless-runner core against a behavioural game model.
module tb_not_a_dinosaur_runner;

  localparam int TICK_DIV = 4;
  localparam int LANE_LEN = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  // Behavioural model: 0 idle, 1 running, 2 over
  int         m_state;
  logic [7:0] m_lfsr;
  int         m_presc;
  int         m_lane[LANE_LEN];
  int         m_jcnt, m_height, m_score;
  bit         m_tick;

  not_a_dinosaur_runner #(.TICK_DIV(TICK_DIV), .LANE_LEN(LANE_LEN)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  function automatic int height_of(int phase);
    case (phase)
      1: return 1;
      2: return 2;
      3, 4, 5: return 3;
      6: return 2;
      7: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic game_tick();
    bit spawn;
    if (m_jcnt == 0 && m_height == 0 && ui_in[0]) m_jcnt = 1;
    else if (m_jcnt != 0) m_jcnt = (m_jcnt + 1) % 8;
    m_height = height_of(m_jcnt);
    spawn = (m_lfsr % 8 == 0) && m_lane[LANE_LEN-1] == 0 && m_lane[LANE_LEN-2] == 0
            && m_lane[LANE_LEN-3] == 0;
    for (int i = 0; i < LANE_LEN - 1; i++) m_lane[i] = m_lane[i+1];
    m_lane[LANE_LEN-1] = spawn ? 1 : 0;
    if (m_lane[0] != 0 && m_height == 0) m_state = 2;
    else if (m_score < 255) m_score++;
  endtask

  task automatic model_clear();
    for (int i = 0; i < LANE_LEN; i++) m_lane[i] = 0;
    m_presc = 0; m_jcnt = 0; m_height = 0; m_score = 0;
  endtask

  task automatic model_step();
    logic [7:0] nl;
    bit ntick;
    if (rst) begin
      m_state = 0; m_lfsr = 8'h01; m_tick = 0;
      model_clear();
      return;
    end
    if (!ena) return;
    nl = m_lfsr[0] ? ((m_lfsr >> 1) ^ 8'hB8) : (m_lfsr >> 1);
    ntick = 0;
    if (m_state != 1) begin
      if (ui_in[1]) begin
        m_state = 1;
        model_clear();
      end
    end else if (!ui_in[2]) begin
      if (m_presc == TICK_DIV - 1) begin
        m_presc = 0;
        ntick = 1;
        game_tick();
      end else begin
        m_presc++;
      end
    end
    m_tick = ntick;
    m_lfsr = nl;
  endtask

  function automatic logic [7:0] exp_uo();
    logic [7:0] e;
    e = 8'h00;
    e[2:0] = 3'(m_height);
    e[4] = (m_lane[0] != 0);
    e[5] = (m_state == 2);
    e[6] = (m_state == 1);
    e[7] = m_tick;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic restart_game();
    ui_in = 8'h00;
    rst = 1'b1; step(); rst = 1'b0;
    ui_in[1] = 1'b1; step(); ui_in[1] = 1'b0;
  endtask

  task automatic test_reset();
    ena = 1'b1; ui_in = 8'h00; uio_in = 8'($urandom);
    rst = 1'b1; step(); step(); rst = 1'b0;
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_uo: got %h expected 00", uo_out); end
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL reset_score: got %h expected 00", uio_out); end
    checks++; if (uio_oe !== 8'hFF) begin errors++; $display("FAIL reset_oe: got %h expected ff", uio_oe); end
    for (int i = 0; i < 100; i++) begin
      ui_in = {5'($urandom), 1'b0, 1'b0, 1'($urandom)};
      step();
      checks++;
      if (uo_out !== 8'h00) begin errors++; $display("FAIL idle_quiet: got %h expected 00 at cycle %0d", uo_out, i); end
    end
    ui_in = 8'h00;
  endtask

  task automatic test_start_score();
    int ticks = 0;
    int last = -1;
    ui_in[1] = 1'b1; step(); ui_in[1] = 1'b0;
    checks++; if (uo_out[6] !== 1'b1) begin errors++; $display("FAIL start_running: got %b expected 1", uo_out[6]); end
    for (int c = 0; c < 40; c++) begin
      step();
      checks++;
      if (uo_out !== exp_uo() || uio_out !== 8'(m_score)) begin
        errors++; $display("FAIL start_model: got %h/%h expected %h/%h", uo_out, uio_out, exp_uo(), 8'(m_score));
      end
      if (uo_out[7]) begin
        ticks++;
        checks++;
        if (uio_out !== 8'(ticks)) begin errors++; $display("FAIL score_count: got %0d expected %0d", uio_out, ticks); end
        if (last >= 0) begin
          checks++;
          if (c - last != TICK_DIV) begin errors++; $display("FAIL tick_period: got %0d expected %0d", c - last, TICK_DIV); end
        end
        last = c;
      end
    end
    checks++; if (ticks != 10) begin errors++; $display("FAIL tick_total: got %0d expected 10", ticks); end
  endtask

  task automatic test_jump();
    int exp_h[8] = '{1, 2, 3, 3, 3, 2, 1, 0};
    int n = 0;
    restart_game();
    ui_in[0] = 1'b1;
    for (int c = 0; c < 8 * TICK_DIV + 8 && n < 8; c++) begin
      step();
      checks++;
      if (uo_out !== exp_uo()) begin errors++; $display("FAIL jump_model: got %h expected %h", uo_out, exp_uo()); end
      if (uo_out[7]) begin
        ui_in[0] = 1'b0;
        checks++;
        if (uo_out[2:0] !== 3'(exp_h[n])) begin errors++; $display("FAIL jump_height%0d: got %0d expected %0d", n, uo_out[2:0], exp_h[n]); end
        n++;
      end
    end
    checks++; if (n != 8) begin errors++; $display("FAIL jump_ticks: got %0d expected 8", n); end
  endtask

  task automatic test_jump_hold();
    int n = 0;
    restart_game();
    ui_in[0] = 1'b1;
    for (int c = 0; c < 12 * TICK_DIV + 8 && n < 12; c++) begin
      step();
      checks++;
      if (uo_out !== exp_uo() || uio_out !== 8'(m_score)) begin
        errors++; $display("FAIL hold_model: got %h/%h expected %h/%h", uo_out, uio_out, exp_uo(), 8'(m_score));
      end
      if (uo_out[7]) begin
        n++;
        if (n == 8 || n == 9) begin
          checks++;
          if (uo_out[2:0] !== ((n == 8) ? 3'd0 : 3'd1)) begin
            errors++; $display("FAIL hold_retrigger%0d: got %0d expected %0d", n, uo_out[2:0], (n == 8) ? 0 : 1);
          end
        end
      end
    end
    ui_in[0] = 1'b0;
  endtask

  task automatic run_to_over(input string tag, output int ticks);
    bit over = 0;
    ticks = 0;
    for (int c = 0; c < 3000 && !over; c++) begin
      step();
      checks++;
      if (uo_out !== exp_uo() || uio_out !== 8'(m_score)) begin
        errors++; $display("FAIL %s_model: got %h/%h expected %h/%h", tag, uo_out, uio_out, exp_uo(), 8'(m_score));
      end
      if (uo_out[7]) ticks++;
      over = uo_out[5];
    end
    checks++;
    if (!over) begin errors++; $display("FAIL %s_timeout: got no game_over expected game_over", tag); end
  endtask

  task automatic test_collision();
    int ticks;
    restart_game();
    run_to_over("collide", ticks);
    checks++; if (uo_out[6] !== 1'b0) begin errors++; $display("FAIL over_running: got %b expected 0", uo_out[6]); end
    checks++; if (uo_out[4] !== 1'b1) begin errors++; $display("FAIL over_obstacle: got %b expected 1", uo_out[4]); end
    checks++; if (uio_out !== 8'(ticks - 1)) begin errors++; $display("FAIL over_score: got %0d expected %0d", uio_out, ticks - 1); end
    for (int c = 0; c < 40; c++) begin
      ui_in[0] = 1'($urandom);
      step();
      checks++;
      if (uio_out !== 8'(ticks - 1) || uo_out[7] !== 1'b0 || uo_out[5] !== 1'b1) begin
        errors++; $display("FAIL over_frozen: got %h/%0d expected over, no tick, score %0d", uo_out, uio_out, ticks - 1);
      end
    end
    ui_in = 8'h00;
  endtask

  task automatic test_restart_from_over();
    ui_in[1] = 1'b1; step(); ui_in[1] = 1'b0;
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL restart_score: got %0d expected 0", uio_out); end
    checks++; if (uo_out !== 8'h40) begin errors++; $display("FAIL restart_uo: got %h expected 40", uo_out); end
  endtask

  task automatic test_pause();
    int n = 0;
    int wait_cnt = 0;
    logic [7:0] snap;
    restart_game();
    for (int c = 0; c < 20 && n < 2; c++) begin
      step();
      if (uo_out[7]) n++;
    end
    checks++; if (n != 2) begin errors++; $display("FAIL pause_pre: got %0d ticks expected 2", n); end
    ui_in[2] = 1'b1;
    snap = exp_uo() & 8'h7F;
    for (int c = 0; c < 20; c++) begin
      ui_in[0] = 1'($urandom);
      step();
      checks++;
      if (uo_out !== snap || uio_out !== 8'd2) begin
        errors++; $display("FAIL pause_frozen: got %h/%0d expected %h/2", uo_out, uio_out, snap);
      end
    end
    ui_in = 8'h00;
    for (int c = 1; c <= 10 && wait_cnt == 0; c++) begin
      step();
      if (uo_out[7]) wait_cnt = c;
    end
    checks++; if (wait_cnt != TICK_DIV) begin errors++; $display("FAIL pause_resume: got %0d clocks expected %0d", wait_cnt, TICK_DIV); end
  endtask

  task automatic test_ena();
    int ticks;
    logic [7:0] snap_uo, snap_sc;
    restart_game();
    repeat (9) step();
    snap_uo = exp_uo(); snap_sc = 8'(m_score);
    ena = 1'b0;
    for (int c = 0; c < 30; c++) begin
      ui_in = 8'($urandom);
      step();
      checks++;
      if (uo_out !== snap_uo || uio_out !== snap_sc) begin
        errors++; $display("FAIL ena_hold: got %h/%h expected %h/%h", uo_out, uio_out, snap_uo, snap_sc);
      end
    end
    ui_in = 8'h00; ena = 1'b1;
    run_to_over("ena", ticks);
  endtask

  task automatic test_rst_mid_run();
    ui_in[1] = 1'b1; step(); ui_in[1] = 1'b0;
    repeat (10) step();
    ena = 1'b0; rst = 1'b1; step(); rst = 1'b0; ena = 1'b1;
    checks++; if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
      errors++; $display("FAIL rst_mid: got %h/%h expected 00/00", uo_out, uio_out);
    end
    for (int c = 0; c < 10; c++) begin
      step();
      checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL rst_idle: got %h expected 00", uo_out); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      ui_in = {5'($urandom), 1'($urandom_range(9) == 0), 1'($urandom_range(29) == 0), 1'($urandom_range(2) == 0)};
      ena = ($urandom_range(15) != 0);
      rst = ($urandom_range(999) == 0);
      uio_in = 8'($urandom);
      step();
      checks++;
      if (uo_out !== exp_uo() || uio_out !== 8'(m_score)) begin
        errors++; $display("FAIL random_model: got %h/%h expected %h/%h at cycle %0d", uo_out, uio_out, exp_uo(), 8'(m_score), c);
      end
    end
    rst = 1'b0; ena = 1'b1; ui_in = 8'h00;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    test_reset();
    test_start_score();
    test_jump();
    test_jump_hold();
    test_collision();
    test_restart_from_over();
    test_pause();
    test_ena();
    test_rst_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
